// File: rtl/sprite_compositor_pkg.sv
// Shared colour codes and default geometry
// for the sprite compositor.
package sprite_compositor_pkg;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  localparam int DEF_COORD_W   = 10;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_PLAYER_W  = 16;
  localparam int DEF_PLAYER_H  = 16;
  localparam int DEF_CAR_W     = 32;
  localparam int DEF_CAR_H     = 16;
  localparam int DEF_CAR_Y0    = 64;
  localparam int DEF_PITCH     = 40;
  localparam int DEF_SAFE_H    = 32;
  localparam int DEF_FLASH     = 60;

endpackage

// File: rtl/sprite_compositor_rect_hit.sv
// Combinational point-in-rectangle test with
// a one-bit-wider far edge so sprites never wrap.
module rect_hit #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] size_x,
  input  logic [COORD_W-1:0] size_y,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] v,
  output logic               hit
);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, pos_x} + {1'b0, size_x};
  assign y_end = {1'b0, pos_y} + {1'b0, size_y};

  assign hit = (h >= pos_x) && ({1'b0, h} < x_end)
            && (v >= pos_y) && ({1'b0, v} < y_end);

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage per-pixel sprite compositor with
// per-frame player/car collision and hit blink.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int NUM_CARS      = 8,
  parameter int COORD_W       = DEF_COORD_W,
  parameter int H_DISPLAY     = DEF_H_DISPLAY,
  parameter int V_DISPLAY     = DEF_V_DISPLAY,
  parameter int PLAYER_WIDTH  = DEF_PLAYER_W,
  parameter int PLAYER_HEIGHT = DEF_PLAYER_H,
  parameter int CAR_WIDTH     = DEF_CAR_W,
  parameter int CAR_HEIGHT    = DEF_CAR_H,
  parameter int CAR_Y0        = DEF_CAR_Y0,
  parameter int LANE_PITCH    = DEF_PITCH,
  parameter int SAFE_X        = 0,
  parameter int SAFE_WIDTH    = DEF_H_DISPLAY,
  parameter int SAFE_Y0       = 0,
  parameter int SAFE_Y1       = 224,
  parameter int SAFE_Y2       = 448,
  parameter int SAFE_HEIGHT   = DEF_SAFE_H,
  parameter int FLASH_FRAMES  = DEF_FLASH,
  localparam int LANE_W =
    (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [COORD_W-1:0]          h_count,
  input  logic [COORD_W-1:0]          v_count,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [COORD_W-1:0]          player_x,
  input  logic [COORD_W-1:0]          player_y,
  input  logic [NUM_CARS*COORD_W-1:0] car_x,
  input  logic [NUM_CARS-1:0]         car_en,
  input  logic [2:0]                  bg_rgb,
  output logic                        VGA_R2,
  output logic                        VGA_G2,
  output logic                        VGA_B2,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        collision,
  output logic [LANE_W-1:0]           hit_lane,
  output logic                        flash_active
);

  localparam int FLASH_W =
    (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;

  localparam logic [COORD_W-1:0] H_DISP = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_DISP = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_DISPLAY - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_DISPLAY - 1);

  function automatic logic [LANE_W-1:0] lowest_lane(
    input logic [NUM_CARS-1:0] hits
  );
    lowest_lane = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (hits[i]) lowest_lane = LANE_W'(i);
    end
  endfunction

  logic                player_in;
  logic [NUM_CARS-1:0] car_in;
  logic [2:0]          safe_in;

  rect_hit #(.COORD_W(COORD_W)) u_player (
    .pos_x  (player_x),
    .pos_y  (player_y),
    .size_x (COORD_W'(PLAYER_WIDTH)),
    .size_y (COORD_W'(PLAYER_HEIGHT)),
    .h      (h_count),
    .v      (v_count),
    .hit    (player_in)
  );

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    rect_hit #(.COORD_W(COORD_W)) u_car (
      .pos_x  (car_x[i*COORD_W +: COORD_W]),
      .pos_y  (COORD_W'(CAR_Y0 + i * LANE_PITCH)),
      .size_x (COORD_W'(CAR_WIDTH)),
      .size_y (COORD_W'(CAR_HEIGHT)),
      .h      (h_count),
      .v      (v_count),
      .hit    (car_in[i])
    );
  end

  for (genvar z = 0; z < 3; z++) begin : g_safe
    localparam int TOP =
      (z == 0) ? SAFE_Y0 : ((z == 1) ? SAFE_Y1 : SAFE_Y2);
    rect_hit #(.COORD_W(COORD_W)) u_safe (
      .pos_x  (COORD_W'(SAFE_X)),
      .pos_y  (COORD_W'(TOP)),
      .size_x (COORD_W'(SAFE_WIDTH)),
      .size_y (COORD_W'(SAFE_HEIGHT)),
      .h      (h_count),
      .v      (v_count),
      .hit    (safe_in[z])
    );
  end

  logic                vis_s1;
  logic                player_s1;
  logic [NUM_CARS-1:0] car_s1;
  logic                safe_s1;
  logic                eof_s1;
  logic                hs_s1;
  logic                vs_s1;
  logic [2:0]          bg_s1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vis_s1    <= 1'b0;
      player_s1 <= 1'b0;
      car_s1    <= '0;
      safe_s1   <= 1'b0;
      eof_s1    <= 1'b0;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
      bg_s1     <= '0;
    end else begin
      vis_s1    <= (h_count < H_DISP) && (v_count < V_DISP);
      player_s1 <= player_in;
      car_s1    <= car_in & car_en;
      safe_s1   <= |safe_in;
      eof_s1    <= (h_count == H_LAST) && (v_count == V_LAST);
      hs_s1     <= hsync_in;
      vs_s1     <= vsync_in;
      bg_s1     <= bg_rgb;
    end
  end

  logic [FLASH_W-1:0] flash_cnt;
  logic [2:0]         colour;

  always_comb begin
    colour = bg_s1;
    if (!vis_s1)         colour = COL_BLACK;
    else if (player_s1)  colour = flash_cnt[0] ? COL_WHITE : COL_GREEN;
    else if (|car_s1)    colour = COL_RED;
    else if (safe_s1)    colour = COL_MAGENTA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      VGA_R2    <= 1'b0;
      VGA_G2    <= 1'b0;
      VGA_B2    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      {VGA_R2, VGA_G2, VGA_B2} <= colour;
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
    end
  end

  logic              overlap;
  logic              frame_flag;
  logic [LANE_W-1:0] pending_lane;

  assign overlap = vis_s1 && player_s1 && (|car_s1);

  // The first overlap of a frame owns the reported lane.
  always_ff @(posedge CLK) begin
    if (RST) begin
      collision    <= 1'b0;
      hit_lane     <= '0;
      frame_flag   <= 1'b0;
      pending_lane <= '0;
      flash_cnt    <= '0;
    end else begin
      collision <= 1'b0;
      if (eof_s1) begin
        frame_flag <= 1'b0;
        if (frame_flag || overlap) begin
          collision <= 1'b1;
          hit_lane  <= frame_flag ? pending_lane : lowest_lane(car_s1);
          flash_cnt <= FLASH_W'(FLASH_FRAMES);
        end else if (flash_cnt != '0) begin
          flash_cnt <= flash_cnt - 1'b1;
        end
      end else if (overlap && !frame_flag) begin
        frame_flag   <= 1'b1;
        pending_lane <= lowest_lane(car_s1);
      end
    end
  end

  assign flash_active = (flash_cnt != '0);

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a
// frame-level behavioural model checked every cycle.
module tb_sprite_compositor;

  localparam int NC    = 8;
  localparam int CW    = 10;
  localparam int LW    = 3;
  localparam int PITCH = 58;
  localparam int FLASH = 60;

  logic           CLK = 1'b0;
  logic           RST;
  logic [CW-1:0]  h_count, v_count;
  logic           hsync_in, vsync_in;
  logic [CW-1:0]  player_x, player_y;
  logic [NC*CW-1:0] car_x;
  logic [NC-1:0]  car_en;
  logic [2:0]     bg_rgb;
  logic           VGA_R2, VGA_G2, VGA_B2;
  logic           hsync_out, vsync_out;
  logic           collision;
  logic [LW-1:0]  hit_lane;
  logic           flash_active;

  always #5 CLK = ~CLK;

  sprite_compositor #(
    .NUM_CARS   (NC),
    .COORD_W    (CW),
    .LANE_PITCH (PITCH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .h_count      (h_count),
    .v_count      (v_count),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .player_x     (player_x),
    .player_y     (player_y),
    .car_x        (car_x),
    .car_en       (car_en),
    .bg_rgb       (bg_rgb),
    .VGA_R2       (VGA_R2),
    .VGA_G2       (VGA_G2),
    .VGA_B2       (VGA_B2),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .collision    (collision),
    .hit_lane     (hit_lane),
    .flash_active (flash_active)
  );

  logic [2:0] rgb;
  assign rgb = {VGA_R2, VGA_G2, VGA_B2};

  int checks = 0;
  int errors = 0;

  // model: frame state and the pixel captured one edge ago
  int       m_flash, m_flag, m_pend, m_hl;
  bit       p_vis, p_ph, p_safe, p_eof, p_hs, p_vs, p_car;
  int       p_lane;
  logic [2:0] p_bg;
  logic [2:0] e_rgb;
  bit       e_hs, e_vs, e_col;

  function automatic bit in_span(int c, int p, int s);
    return (c >= p) && (c < p + s);
  endfunction

  task automatic model_edge();
    bit ov;
    int h, v;
    if (RST) begin
      m_flash = 0; m_flag = 0; m_pend = 0; m_hl = 0;
      p_vis = 0; p_ph = 0; p_safe = 0; p_eof = 0;
      p_hs = 0; p_vs = 0; p_car = 0; p_lane = -1; p_bg = 0;
      e_rgb = 0; e_hs = 0; e_vs = 0; e_col = 0;
      return;
    end
    if (!p_vis)      e_rgb = 3'b000;
    else if (p_ph)   e_rgb = (m_flash % 2 == 1) ? 3'b111 : 3'b010;
    else if (p_car)  e_rgb = 3'b100;
    else if (p_safe) e_rgb = 3'b101;
    else             e_rgb = p_bg;
    e_hs = p_hs;
    e_vs = p_vs;
    e_col = 0;
    ov = p_vis && p_ph && (p_lane >= 0);
    if (p_eof) begin
      if (m_flag != 0 || ov) begin
        e_col = 1;
        m_hl = (m_flag != 0) ? m_pend : p_lane;
        m_flash = FLASH;
      end else if (m_flash > 0) begin
        m_flash = m_flash - 1;
      end
      m_flag = 0;
    end else if (ov && m_flag == 0) begin
      m_flag = 1;
      m_pend = p_lane;
    end
    h = int'(h_count);
    v = int'(v_count);
    p_vis = (h < 640) && (v < 480);
    p_ph = in_span(h, int'(player_x), 16) && in_span(v, int'(player_y), 16);
    p_lane = -1;
    p_car = 0;
    for (int i = 0; i < NC; i++) begin
      if (car_en[i] && in_span(h, int'(car_x[i*CW +: CW]), 32)
          && in_span(v, 64 + PITCH * i, 16)) begin
        p_car = 1;
        if (p_lane < 0) p_lane = i;
      end
    end
    p_safe = in_span(h, 0, 640) && (in_span(v, 0, 32)
           || in_span(v, 224, 32) || in_span(v, 448, 32));
    p_eof = (h == 639) && (v == 479);
    p_hs = hsync_in;
    p_vs = vsync_in;
    p_bg = bg_rgb;
  endtask

  task automatic tick();
    logic [10:0] act, exp;
    @(posedge CLK);
    model_edge();
    #1;
    act = {rgb, hsync_out, vsync_out, collision, hit_lane, flash_active};
    exp = {e_rgb, e_hs, e_vs, e_col, LW'(m_hl), (m_flash != 0)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle t=%0t got %b want %b", $time, act, exp);
    end
  endtask

  task automatic lit(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic pix(int h, int v);
    h_count  = CW'(h);
    v_count  = CW'(v);
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    tick();
  endtask

  task automatic set_car(int i, int x);
    car_x[i*CW +: CW] = CW'(x);
  endtask

  task automatic set_player(int x, int y);
    player_x = CW'(x);
    player_y = CW'(y);
  endtask

  initial begin
    RST = 1'b1;
    h_count = 10'd123; v_count = 10'd10;
    hsync_in = 1'b1; vsync_in = 1'b1;
    for (int i = 0; i < NC; i++) set_car(i, 900);
    car_en = '1;
    bg_rgb = 3'b001;
    set_player(500, 400);

    for (int i = 0; i < 3; i++) tick();
    lit("reset_outs", int'({rgb, hsync_out, vsync_out, collision,
                            hit_lane, flash_active}), 0);

    RST = 1'b0;
    set_car(0, 90);
    pix(100, 64);
    lit("latency_1", int'(rgb), 0);
    pix(101, 64);
    lit("car_red", int'(rgb), 3'b100);
    car_en[0] = 1'b0;
    pix(100, 64);
    car_en[0] = 1'b1;
    pix(102, 64);
    lit("car_disabled", int'(rgb), 3'b001);

    pix(639, 479);
    set_player(300, 122);
    set_car(1, 290);
    pix(305, 125);
    set_player(300, 238);
    set_car(3, 295);
    pix(305, 240);
    set_player(500, 400);
    pix(639, 479);
    pix(0, 0);
    lit("hit_pulse", int'(collision), 1);
    lit("hit_lane1", int'(hit_lane), 1);
    lit("flash_on", int'(flash_active), 1);
    pix(1, 0);
    lit("pulse_one_cycle", int'(collision), 0);

    set_player(10, 160);
    for (int f = 1; f <= 60; f++) begin
      pix(12, 162);
      if (f == 60) lit("flash_last", int'(flash_active), 1);
      pix(639, 479);
      if (f == 1) lit("blink_even", int'(rgb), 3'b010);
      if (f == 2) lit("blink_odd", int'(rgb), 3'b111);
    end
    pix(0, 0);
    lit("flash_off", int'(flash_active), 0);

    set_car(0, 1020);
    set_car(2, 600);
    pix(5, 70);
    pix(1021, 70);
    lit("no_wrap", int'(rgb), 3'b001);
    pix(630, 185);
    lit("invisible", int'(rgb), 0);
    pix(0, 1);
    lit("right_edge_car", int'(rgb), 3'b100);
    set_car(2, 900);

    set_player(500, 400);
    pix(639, 479);
    set_player(630, 470);
    set_car(7, 620);
    pix(639, 479);
    set_player(500, 400);
    pix(0, 0);
    lit("eof_hit", int'(collision), 1);
    lit("eof_lane7", int'(hit_lane), 7);
    pix(639, 479);
    pix(0, 0);
    lit("flag_cleared", int'(collision), 0);

    set_player(300, 122);
    pix(305, 125);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    set_player(500, 400);
    pix(639, 479);
    pix(0, 0);
    lit("reset_discard", int'(collision), 0);
    lit("reset_flash", int'(flash_active), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor of the per-pixel colour generator in the VGA frogger datapath.
- Takes the VGA counters, player position and N car positions, and produces the registered 1-bit-per-channel RGB plus delay-matched syncs.
- New over the previous generation: N car lanes with an enable mask, a 2-stage pipeline, and per-frame player/car collision detection with the lane of the hit.
- Adds a player blink effect after a hit. Sits between the VGA timing generator and the VGA pins; the game FSM consumes collision outputs.

Parameters:
NUM_CARS, 8, number of car lanes (1..16)
COORD_W, 10, width of all coordinates and counters
H_DISPLAY, 640, visible pixels per line
V_DISPLAY, 480, visible lines per frame
PLAYER_WIDTH, 16, player sprite width
PLAYER_HEIGHT, 16, player sprite height
CAR_WIDTH, 32, car sprite width
CAR_HEIGHT, 16, car sprite height
CAR_Y0, 64, top line of lane 0
LANE_PITCH, 40, vertical distance between lanes; lane i top = CAR_Y0 + i*LANE_PITCH
SAFE_X, 0, safe-zone left edge
SAFE_WIDTH, 640, safe-zone width
SAFE_Y0/SAFE_Y1/SAFE_Y2, 0/224/448, top lines of the three safe zones
SAFE_HEIGHT, 32, safe-zone height
FLASH_FRAMES, 60, frames of player blink after a collision

Ports:
CLK  in  1  pixel clock
RST  in  1  synchronous active-high reset
h_count  in  COORD_W  horizontal pixel counter
v_count  in  COORD_W  vertical line counter
hsync_in  in  1  hsync aligned with h_count
vsync_in  in  1  vsync aligned with v_count
player_x, player_y  in  COORD_W  player top-left
car_x  in  NUM_CARS*COORD_W  packed car x positions; lane i at bits [i*COORD_W +: COORD_W]
car_en  in  NUM_CARS  lane enable; disabled lanes are neither drawn nor collided
bg_rgb  in  3  background colour {R,G,B}
VGA_R2, VGA_G2, VGA_B2  out  1  registered colour
hsync_out, vsync_out  out  1  syncs delayed to match colour
collision  out  1  one-cycle pulse, frame contained a player/car overlap
hit_lane  out  clog2(NUM_CARS) (min 1)  lowest-index lane that overlapped, valid with collision, held until next pulse
flash_active  out  1  high while blink counter nonzero

Behaviour:
- Clock/reset: single clock CLK; synchronous active-high RST. During RST, all outputs are 0, the pipeline is cleared, and the frame-collide flag and blink counter are 0. RST mid-frame discards accumulated collision; no pulse is issued for that frame.
- Arithmetic: every "pos + size" is computed at COORD_W+1 bits, so sprites near 2^COORD_W do not wrap. Hit test is inclusive-left/top, exclusive-right/bottom.
- Stage 1 (register):
  - visible = h<H_DISPLAY && v<V_DISPLAY
  - player_hit
  - car_hit[i] = in-rect && car_en[i]
  - safe_hit = any of 3 zones
  - eof = (h==H_DISPLAY-1 && v==V_DISPLAY-1)
  - syncs delayed 1
- Stage 2 (register): RGB priority mux.
  - Not visible: 000.
  - Player: 010, or 111 when flash_cnt[0]==1.
  - Any car: 100.
  - Safe: 101.
  - Otherwise bg_rgb.
  - Syncs delayed again.
  - Total latency is 2 cycles from counters to pins.
- Collision accumulate (stage-2 side):
  - overlap = visible_s1 && player_hit_s1 && |car_hit_s1.
  - On the first overlap in a frame, set frame_flag and latch the lowest set index of car_hit as pending_lane. Later overlaps in the same frame do not change pending_lane.
- Frame end: when eof_s1, if frame_flag or overlap on that same pixel:
  - collision=1 next cycle;
  - hit_lane=pending_lane, or this pixel's lane if the flag was clear;
  - flash_cnt loads FLASH_FRAMES.
  - frame_flag clears on every eof regardless.
- Flash counter: decrements by 1 on every eof with no collision, saturating at 0. A collision while already flashing reloads FLASH_FRAMES. flash_active = (flash_cnt!=0).
- Misc: car_en changes take effect on the next pixel, with no frame alignment. Overlapping cars render identically.

Decomposition:
- Shared package (constants include): colour codes (COL_BLACK, COL_GREEN, COL_RED, COL_MAGENTA, COL_WHITE) and default display/sprite dimensions.
- Sub-module rect_hit (pos/size/count compare, COORD_W-parametrised, combinational), instantiated for the player, NUM_CARS cars, and 3 safe zones.
- Lowest-index priority encoder as a function inside sprite_compositor.

Test Plan:
- RST=1 for 3 cycles mid-line -> all outputs 0; after release, the first pixel colour appears exactly 2 cycles after its counters.
- Pixel (100,64), car_x lane0=90, car_en=1, player far away -> RGB 100 at cycle+2; with car_en[0]=0 -> bg_rgb (e.g. 001).
- Player (300,104) overlaps lanes 1 and 3 in the same frame (lane 3 scanned first by line? no, lane1 first) -> single collision pulse at eof+1, hit_lane=1, flash_active=1, flash_cnt=60.
- No overlap for 60 frames after a hit -> flash_active falls after the 60th eof; player colour alternates 111/010 per frame.
- Car at x=1020, CAR_WIDTH=32 (sum>1023) -> no wrap; pixel h=5 is not drawn red.
- Overlap only on last visible pixel (639,479) -> collision pulse still issued for that frame; frame_flag is clear next frame.
